// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures line/frame timing from hsync/vsync and recovers
// pixel coordinates. Define VGA_SYNC_MONITOR_STATS_EN to enable the err_count lock-loss counter.
module vga_sync_monitor #(
  parameter int H_DISP       = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC       = 96,
  parameter int H_TOTAL      = 800,
  parameter int V_DISP       = 480,
  parameter int V_SYNC_START = 513,
  parameter int V_SYNC       = 2,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       CLK_50MHZ,
  input  logic       RESET,
  input  logic       p_tick,
  input  logic       hsync,
  input  logic       vsync,
  output logic       locked,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       frame_start,
  output logic       line_err,
  output logic [9:0] h_period,
  output logic [9:0] v_period,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_DISP_C       = 10'(H_DISP);
  localparam logic [9:0] H_SYNC_START_C = 10'(H_SYNC_START);
  localparam logic [9:0] H_SYNC_C       = 10'(H_SYNC);
  localparam logic [9:0] H_TOTAL_C      = 10'(H_TOTAL);
  localparam logic [9:0] H_LAST_C       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_DISP_C       = 10'(V_DISP);
  localparam logic [9:0] V_SYNC_START_C = 10'(V_SYNC_START);
  localparam logic [9:0] V_SYNC_C       = 10'(V_SYNC);
  localparam logic [9:0] V_TOTAL_C      = 10'(V_TOTAL);
  localparam logic [9:0] V_LAST_C       = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX        = 10'd1023;
  localparam logic [9:0] CNT_PRE_MAX    = 10'd1022;
  localparam logic [2:0] LOCK_C         = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  logic       hs_q, hs_d, vs_q, vs_d;
  logic [9:0] hcnt_q, hcnt_d, hwid_q, hwid_d;
  logic [9:0] lcnt_q, lcnt_d, vwid_q, vwid_d;
  logic [9:0] h_period_q, h_period_d, v_period_q, v_period_d;
  logic [9:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic       h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic       frame_bad_q, frame_bad_d;
  logic       frame_start_q, frame_start_d, line_err_q, line_err_d;

  state_t     state_q;
  logic [2:0] good_q;
  logic       locked_q;

  logic hrise, hfall, vrise, vfall;
  logic period_bad, width_bad, timeout, line_bad, vwidth_bad;
  logic frame_good, lock_lost, line_wrap;

  // Period/width checks are suppressed until a first hrise/vrise gives a valid reference.
  always_comb begin
    hrise      = p_tick & hsync & ~hs_q;
    hfall      = p_tick & ~hsync & hs_q;
    vrise      = p_tick & vsync & ~vs_q;
    vfall      = p_tick & ~vsync & vs_q;
    period_bad = hrise & h_seen_q & (hcnt_q != H_TOTAL_C);
    width_bad  = hfall & h_seen_q & (hwid_q != H_SYNC_C);
    timeout    = p_tick & ~hrise & (hcnt_q == CNT_PRE_MAX);
    line_bad   = period_bad | width_bad | timeout;
    vwidth_bad = vfall & v_seen_q & (vwid_q != V_SYNC_C);
    // A bad line on the vrise tick still belongs to the frame being judged.
    frame_good = (lcnt_q == V_TOTAL_C) & ~frame_bad_q & ~line_bad;
    lock_lost  = (state_q == ST_LOCKED) & (line_bad | (vrise & ~frame_good));
  end

  always_comb begin
    hs_d          = hs_q;
    vs_d          = vs_q;
    hcnt_d        = hcnt_q;
    hwid_d        = hwid_q;
    lcnt_d        = lcnt_q;
    vwid_d        = vwid_q;
    h_period_d    = h_period_q;
    v_period_d    = v_period_q;
    h_seen_d      = h_seen_q;
    v_seen_d      = v_seen_q;
    frame_bad_d   = frame_bad_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    frame_start_d = 1'b0;
    line_err_d    = 1'b0;
    line_wrap     = 1'b0;
    if (p_tick) begin
      hs_d          = hsync;
      vs_d          = vsync;
      frame_start_d = vrise;
      line_err_d    = line_bad;

      if (hrise) begin
        hcnt_d     = 10'd1;
        h_period_d = hcnt_q;
        h_seen_d   = 1'b1;
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_d = hcnt_q + 10'd1;
      end

      // The rising tick itself is counted so a width of H_SYNC ticks reads H_SYNC at hfall.
      if (hrise) begin
        hwid_d = 10'd1;
      end else if (hsync && hwid_q != CNT_MAX) begin
        hwid_d = hwid_q + 10'd1;
      end

      if (vrise) begin
        v_period_d = lcnt_q;
        lcnt_d     = {9'd0, hrise};
        vwid_d     = {9'd0, hrise};
        v_seen_d   = 1'b1;
      end else if (hrise) begin
        if (lcnt_q != CNT_MAX) begin
          lcnt_d = lcnt_q + 10'd1;
        end
        if (vsync && vwid_q != CNT_MAX) begin
          vwid_d = vwid_q + 10'd1;
        end
      end

      if (vrise) begin
        frame_bad_d = 1'b0;
      end else if (line_bad || vwidth_bad) begin
        frame_bad_d = 1'b1;
      end

      if (hrise) begin
        pixel_x_d = H_SYNC_START_C;
      end else if (pixel_x_q == H_LAST_C) begin
        pixel_x_d = '0;
        line_wrap = 1'b1;
      end else begin
        pixel_x_d = pixel_x_q + 10'd1;
      end

      if (vrise) begin
        pixel_y_d = V_SYNC_START_C;
      end else if (line_wrap) begin
        pixel_y_d = (pixel_y_q == V_LAST_C) ? 10'd0 : pixel_y_q + 10'd1;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      hcnt_q        <= '0;
      hwid_q        <= '0;
      lcnt_q        <= '0;
      vwid_q        <= '0;
      h_period_q    <= '0;
      v_period_q    <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      frame_bad_q   <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hcnt_q        <= hcnt_d;
      hwid_q        <= hwid_d;
      lcnt_q        <= lcnt_d;
      vwid_q        <= vwid_d;
      h_period_q    <= h_period_d;
      v_period_q    <= v_period_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      frame_bad_q   <= frame_bad_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
      line_err_q    <= line_err_d;
    end
  end

  // SEARCH ignores the first (possibly partial) frame; lock needs LOCK_FRAMES good ones after it.
  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_SEARCH;
      good_q   <= '0;
      locked_q <= 1'b0;
    end else if (p_tick) begin
      case (state_q)
        ST_SEARCH: begin
          if (vrise) begin
            state_q <= ST_MEASURE;
            good_q  <= '0;
          end
        end
        ST_MEASURE: begin
          if (vrise) begin
            if (!frame_good) begin
              good_q <= '0;
            end else if (good_q + 3'd1 >= LOCK_C) begin
              state_q  <= ST_LOCKED;
              good_q   <= '0;
              locked_q <= 1'b1;
            end else begin
              good_q <= good_q + 3'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (lock_lost) begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_SEARCH;
          good_q   <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_SYNC_MONITOR_STATS_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (lock_lost && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

  assign locked      = locked_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign h_period    = h_period_q;
  assign v_period    = v_period_q;
  assign frame_start = frame_start_q;
  assign line_err    = line_err_q;
  assign video_on    = locked_q & (pixel_x_q < H_DISP_C) & (pixel_y_q < V_DISP_C);

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor using a scaled-down raster (32x12) so whole frames stay short.
`timescale 1ns/1ps
module tb_vga_sync_monitor;
  localparam int HD = 16, HSS = 20, HS = 4, HT = 32;
  localparam int VD = 6, VSS = 8, VSW = 2, VT = 12;
  localparam int NSTEP = 14;
`ifdef VGA_SYNC_MONITOR_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef struct {
    int nlines;
    int bad_y;
    int bad_len;
    int bad_hw;
    int trk;
    int exp_locked;
    int exp_vp;
    int exp_le;
    int exp_err;
  } step_t;

  logic       clk = 1'b0, rst = 1'b1, p_tick = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic       locked, video_on, frame_start, line_err;
  logic [9:0] pixel_x, pixel_y, h_period, v_period;
  logic [7:0] err_count;

  int tests = 0, fails = 0;
  int le_cnt = 0, fs_cnt = 0, fs_py = 0, le_first = -1, tick_idx = 0;
  int trk_bad = 0, vo_bad = 0, gate_bad = 0, pulse_bad = 0;
  int cur_x = 0, cur_y = 0;
  bit trk_en = 1'b0;

  always #10 clk = ~clk;

  vga_sync_monitor #(
    .H_DISP(HD), .H_SYNC_START(HSS), .H_SYNC(HS), .H_TOTAL(HT),
    .V_DISP(VD), .V_SYNC_START(VSS), .V_SYNC(VSW), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .CLK_50MHZ(clk), .RESET(rst), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .locked(locked), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .frame_start(frame_start), .line_err(line_err), .h_period(h_period),
    .v_period(v_period), .err_count(err_count)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One pixel tick followed by one idle clock in which nothing may move.
  task automatic do_tick(input logic hs, input logic vs);
    logic [9:0] px;
    @(negedge clk);
    hsync = hs; vsync = vs; p_tick = 1'b1;
    @(posedge clk); #1;
    if (frame_start) begin fs_cnt++; fs_py = int'(pixel_y); end
    if (line_err) begin le_cnt++; if (le_first < 0) le_first = tick_idx; end
    if (trk_en && locked) begin
      if (int'(pixel_x) != cur_x || int'(pixel_y) != cur_y) trk_bad++;
      if (video_on != (cur_x < HD && cur_y < VD)) vo_bad++;
    end
    if (!locked && video_on) vo_bad++;
    px = pixel_x;
    @(negedge clk);
    p_tick = 1'b0;
    @(posedge clk); #1;
    if (pixel_x != px) gate_bad++;
    if (frame_start || line_err) pulse_bad++;
    tick_idx++;
  endtask

  task automatic run_line(input int y, input int x0, input int x1, input int hw);
    for (int x = x0; x < x1; x++) begin
      cur_x = x; cur_y = y;
      do_tick((x >= HSS && x < HSS + hw), (y >= VSS && y < VSS + VSW));
    end
  endtask

  task automatic run_frame(input int y0, input int nlines, input int bad_y,
                           input int bad_len, input int bad_hw);
    for (int y = y0; y < nlines; y++) begin
      if (y == bad_y) run_line(y, 0, bad_len, bad_hw);
      else run_line(y, 0, HT, HS);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t steps[NSTEP];
    steps[0]  = '{VT,   -1, HT,   HS,   0, 0, VSS,    0, 0};
    steps[1]  = '{VT,   -1, HT,   HS,   0, 0, VT,     0, 0};
    steps[2]  = '{VT,    2, HT,   HS-1, 0, 0, VT,     1, 0};
    steps[3]  = '{VT,   -1, HT,   HS,   0, 0, VT,     0, 0};
    steps[4]  = '{VT,   -1, HT,   HS,   0, 1, VT,     0, 0};
    steps[5]  = '{VT,   -1, HT,   HS,   1, 1, VT,     0, 0};
    steps[6]  = '{VT,    2, HT+1, HS,   0, 0, VT,     1, STATS};
    steps[7]  = '{VT,   -1, HT,   HS,   0, 0, VT,     0, STATS};
    steps[8]  = '{VT,   -1, HT,   HS,   0, 1, VT,     0, STATS};
    steps[9]  = '{VT-1, -1, HT,   HS,   0, 1, VT,     0, STATS};
    steps[10] = '{VT,   -1, HT,   HS,   0, 0, VT-1,   0, 2*STATS};
    steps[11] = '{VT,   -1, HT,   HS,   0, 0, VT,     0, 2*STATS};
    steps[12] = '{VT,   -1, HT,   HS,   0, 0, VT,     0, 2*STATS};
    steps[13] = '{VT,   -1, HT,   HS,   1, 1, VT,     0, 2*STATS};

    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_pixel_x", pixel_x, 0);
    check("rst_pixel_y", pixel_y, 0);
    check("rst_video_on", video_on, 0);
    check("rst_pulses", {frame_start, line_err}, 0);
    check("rst_h_period", h_period, 0);
    check("rst_v_period", v_period, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NSTEP; i++) begin
      le_cnt = 0; fs_cnt = 0; trk_bad = 0; vo_bad = 0;
      trk_en = (steps[i].trk != 0);
      run_frame(0, steps[i].nlines, steps[i].bad_y, steps[i].bad_len, steps[i].bad_hw);
      trk_en = 1'b0;
      $display("[TB] step %0d: locked=%0d h_period=%0d v_period=%0d line_err=%0d frame_start=%0d err_count=%0d",
               i, locked, h_period, v_period, le_cnt, fs_cnt, err_count);
      check($sformatf("s%0d_locked", i), locked, steps[i].exp_locked);
      check($sformatf("s%0d_v_period", i), v_period, steps[i].exp_vp);
      check($sformatf("s%0d_h_period", i), h_period, HT);
      check($sformatf("s%0d_line_err", i), le_cnt, steps[i].exp_le);
      check($sformatf("s%0d_frame_start", i), fs_cnt, 1);
      check($sformatf("s%0d_err_count", i), err_count, steps[i].exp_err);
      check($sformatf("s%0d_video_on", i), vo_bad, 0);
      if (steps[i].trk != 0) check($sformatf("s%0d_track", i), trk_bad, 0);
      if (i == 10) check("short_frame_vrise_pixel_y", fs_py, VSS);
    end

    // Asynchronous reset in the middle of a locked frame, then a fresh lock.
    run_frame(0, 3, -1, HT, HS);
    run_line(3, 0, 10, HS);
    $display("[TB] pre-reset: locked=%0d pixel_x=%0d pixel_y=%0d video_on=%0d",
             locked, pixel_x, pixel_y, video_on);
    check("prereset_locked", locked, 1);
    check("prereset_pixel_y", pixel_y, 3);
    check("prereset_pixel_x", pixel_x, 9);
    check("prereset_video_on", video_on, 1);
    #5 rst = 1'b1;
    #1;
    $display("[TB] reset asserted: locked=%0d pixel_x=%0d pixel_y=%0d h_period=%0d v_period=%0d",
             locked, pixel_x, pixel_y, h_period, v_period);
    check("async_rst_locked", locked, 0);
    check("async_rst_pixel_y", pixel_y, 0);
    check("async_rst_pixel_x", pixel_x, 0);
    check("async_rst_video_on", video_on, 0);
    check("async_rst_periods", {h_period, v_period}, 0);
    check("async_rst_err_count", err_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    le_cnt = 0; fs_cnt = 0;
    run_line(3, 10, HT, HS);
    run_frame(4, VT, -1, HT, HS);
    check("relock_vrise1_locked", locked, 0);
    run_frame(0, VT, -1, HT, HS);
    check("relock_vrise2_locked", locked, 0);
    run_frame(0, VT, -1, HT, HS);
    $display("[TB] relock: locked=%0d frame_start=%0d line_err=%0d", locked, fs_cnt, le_cnt);
    check("relock_vrise3_locked", locked, 1);
    check("relock_frame_starts", fs_cnt, 3);
    check("relock_line_err", le_cnt, 0);

    // hsync held low past the 1023-tick timeout.
    le_cnt = 0; le_first = -1; tick_idx = 0;
    for (int i = 0; i < 1100; i++) do_tick(1'b0, 1'b0);
    $display("[TB] hsync idle: line_err=%0d first_at=%0d locked=%0d h_period=%0d",
             le_cnt, le_first, locked, h_period);
    check("timeout_tick", le_first, 1022 - (HT - HSS));
    check("timeout_line_err", le_cnt, 1);
    check("timeout_locked", locked, 0);
    check("timeout_h_period_held", h_period, HT);
    check("timeout_err_count", err_count, STATS);
    run_line(0, 0, HT, HS);
    check("after_timeout_h_period", h_period, 1023);
    check("after_timeout_line_err", le_cnt, 2);
    run_line(1, 0, HT, HS);
    $display("[TB] resume: h_period=%0d line_err=%0d", h_period, le_cnt);
    check("resume_h_period", h_period, HT);
    check("resume_line_err", le_cnt, 2);

    check("tick_gating", gate_bad, 0);
    check("pulse_width", pulse_bad, 0);
    check("video_on_unlocked", vo_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
